palette_unit: RTL and testbench

Final colour stage of the pixel pipeline, directly downstream of the tile fetcher. Consumes its 5-bit `{palette, pixel}` index and produces a registered RGB565 value per screen pixel from a 32-entry palette. The palette table is fetched from VRAM once per frame during vertical blank into a shadow bank, then committed atomically at the start of the next frame.

---
 rtl/palette_unit.sv | 141 ++++++++++++++
 tb/tb_palette_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_unit.sv
// Final colour stage: 32-entry RGB565 palette lookup with a double-buffered bank
// that is refilled from VRAM during vertical blank and committed at frame start.
module palette_unit #(
    parameter logic [15:0] PALETTE_BASE = 16'h2AC0,
    parameter logic [9:0]  ACTIVE_W     = 10'd800,
    parameter logic [9:0]  ACTIVE_H     = 10'd480,
    parameter logic [9:0]  LOAD_LINE    = 10'd480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  true_line,
    input  logic [9:0]  true_column,
    input  logic [4:0]  tile_pixel_in,
    output logic        mem_req,
    output logic [15:0] addr_out,
    input  logic        mem_gnt,
    input  logic [7:0]  data_in,
    output logic [15:0] rgb_out,
    output logic        palette_stale
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        load_ok_q, load_ok_d;
    logic        stale_q, stale_d;
    logic [15:0] rgb_q, rgb_d;
    logic [15:0] shadow_q [32];
    logic [15:0] active_q [32];

    logic        trigger;
    logic        commit;
    logic        shadow_we;
    logic        commit_copy;
    logic        blank;
    logic [4:0]  lut_idx;

    assign trigger = (true_line == LOAD_LINE) && (true_column == 10'd0);
    assign commit  = (true_line == 10'd0) && (true_column == 10'd0);
    assign blank   = (true_line >= ACTIVE_H) || (true_column >= ACTIVE_W);
    // Pixel index 0 of every palette aliases the shared backdrop entry.
    assign lut_idx = (tile_pixel_in[2:0] == 3'd0) ? 5'd0 : tile_pixel_in;

    assign mem_req       = (state_q == S_ISSUE);
    assign addr_out      = mem_req ? (PALETTE_BASE + {10'd0, cnt_q}) : '0;
    assign rgb_out       = rgb_q;
    assign palette_stale = stale_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_ok_d   = load_ok_q;
        stale_d     = stale_q;
        shadow_we   = 1'b0;
        commit_copy = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                end
            end
            S_ISSUE: begin
                if (mem_gnt) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                shadow_we = 1'b1;
                cnt_d     = cnt_q + 6'd1;
                state_d   = (cnt_q == 6'd63) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                load_ok_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Frame commit overrides the loader: a load not finished by now is abandoned.
        if (commit) begin
            if (load_ok_q) begin
                commit_copy = 1'b1;
                load_ok_d   = 1'b0;
                stale_d     = 1'b0;
            end else begin
                stale_d   = 1'b1;
                state_d   = S_IDLE;
                shadow_we = 1'b0;
            end
        end

        rgb_d = blank ? '0 : active_q[lut_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            load_ok_q <= 1'b0;
            stale_q   <= 1'b0;
            rgb_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            load_ok_q <= load_ok_d;
            stale_q   <= stale_d;
            rgb_q     <= rgb_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (shadow_we) begin
                if (cnt_q[0]) begin
                    shadow_q[cnt_q[5:1]][15:8] <= data_in;
                end else begin
                    shadow_q[cnt_q[5:1]][7:0] <= data_in;
                end
            end
            if (commit_copy) begin
                for (int unsigned i = 0; i < 32; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_palette_unit.sv
// Directed self-checking bench for palette_unit: reset, full/stalled/starved
// palette loads, frame commit timing, backdrop aliasing and blanking.
module tb_palette_unit;

    logic        clk;
    logic        reset_n;
    logic [9:0]  true_line;
    logic [9:0]  true_column;
    logic [4:0]  tile_pixel_in;
    logic        mem_req;
    logic [15:0] addr_out;
    logic        mem_gnt;
    logic [7:0]  data_in;
    logic [15:0] rgb_out;
    logic        palette_stale;

    logic [7:0]  vofs;
    int          n_checks;
    int          n_errors;

    palette_unit #(
        .PALETTE_BASE (16'h2AC0),
        .ACTIVE_W     (10'd800),
        .ACTIVE_H     (10'd480),
        .LOAD_LINE    (10'd480)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .true_line     (true_line),
        .true_column   (true_column),
        .tile_pixel_in (tile_pixel_in),
        .mem_req       (mem_req),
        .addr_out      (addr_out),
        .mem_gnt       (mem_gnt),
        .data_in       (data_in),
        .rgb_out       (rgb_out),
        .palette_stale (palette_stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM model: byte at PALETTE_BASE+i holds i+vofs, returned the edge after acceptance.
    always @(posedge clk) begin
        if (mem_req && mem_gnt) begin
            data_in <= 8'(addr_out - 16'h2AC0) + vofs;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input bit stall, input logic [15:0] exp_old);
        int n_req;
        int waited;
        n_req         = 0;
        true_line     = 10'd480;
        true_column   = 10'd0;
        tile_pixel_in = 5'b00_000;
        mem_gnt       = 1'b1;
        step();
        check("req_rise", {15'd0, mem_req}, 16'd1);
        true_line     = 10'd200;
        true_column   = 10'd100;
        tile_pixel_in = 5'b10_011;
        for (int k = 0; k < 64; k++) begin
            waited = 0;
            while (!mem_req && waited < 50) begin
                step();
                waited++;
            end
            if (mem_req) n_req++;
            else check("req_timeout", {15'd0, mem_req}, 16'd1);
            if (k == 0 || k == 5 || k == 63) begin
                check("load_addr", addr_out, 16'h2AC0 + 16'(k));
            end
            if (stall && k == 5) begin
                mem_gnt = 1'b0;
                repeat (10) begin
                    step();
                    check("stall_addr", addr_out, 16'h2AC5);
                    check("stall_req", {15'd0, mem_req}, 16'd1);
                end
                mem_gnt = 1'b1;
            end
            if (k == 32) check("old_bank_midload", rgb_out, exp_old);
            step();
        end
        check("req_count", 16'(n_req), 16'd64);
        repeat (4) step();
        check("req_idle_after", {15'd0, mem_req}, 16'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int n_req;
        n_checks      = 0;
        n_errors      = 0;
        vofs          = 8'h00;
        reset_n       = 1'b0;
        true_line     = 10'd100;
        true_column   = 10'd3;
        tile_pixel_in = 5'b00_000;
        mem_gnt       = 1'b0;
        repeat (3) step();
        check("rst_rgb", rgb_out, 16'h0000);
        check("rst_req", {15'd0, mem_req}, 16'd0);
        check("rst_addr", addr_out, 16'h0000);
        check("rst_stale", {15'd0, palette_stale}, 16'd0);
        reset_n = 1'b1;
        step();

        // Commit with no load this frame marks the palette stale.
        true_line   = 10'd0;
        true_column = 10'd0;
        step();
        check("commit_noload_stale", {15'd0, palette_stale}, 16'd1);

        // Start a load, then assert reset mid-request.
        true_line   = 10'd480;
        true_column = 10'd0;
        step();
        true_line   = 10'd481;
        true_column = 10'd2;
        step();
        step();
        check("midload_req", {15'd0, mem_req}, 16'd1);
        check("midload_addr", addr_out, 16'h2AC0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_req", {15'd0, mem_req}, 16'd0);
        check("async_rst_addr", addr_out, 16'h0000);
        check("async_rst_rgb", rgb_out, 16'h0000);
        check("async_rst_stale", {15'd0, palette_stale}, 16'd0);
        step();
        reset_n   = 1'b1;
        true_line = 10'd100;
        n_req     = 0;
        repeat (20) begin
            step();
            if (mem_req) n_req++;
        end
        check("post_rst_no_req", 16'(n_req), 16'd0);

        // Full load with a grant stall on request 5.
        run_load(1'b1, 16'h0000);
        true_line     = 10'd0;
        true_column   = 10'd0;
        tile_pixel_in = 5'b10_011;
        step();
        check("commit_edge_old", rgb_out, 16'h0000);
        check("commit_stale_clr", {15'd0, palette_stale}, 16'd0);
        true_column = 10'd1;
        step();
        check("entry19", rgb_out, 16'h2726);
        tile_pixel_in = 5'b11_000;
        step();
        check("backdrop", rgb_out, 16'h0100);
        tile_pixel_in = 5'b11_001;
        step();
        check("entry25", rgb_out, 16'h3332);

        // Blanking boundaries.
        tile_pixel_in = 5'b10_011;
        true_line     = 10'd10;
        true_column   = 10'd800;
        step();
        check("blank_col800", rgb_out, 16'h0000);
        true_line   = 10'd480;
        true_column = 10'd5;
        step();
        check("blank_line480", rgb_out, 16'h0000);
        true_line   = 10'd479;
        true_column = 10'd799;
        step();
        check("edge_479_799", rgb_out, 16'h2726);

        // Starved load: grant never arrives before the commit.
        mem_gnt     = 1'b0;
        true_line   = 10'd480;
        true_column = 10'd0;
        step();
        true_line   = 10'd481;
        true_column = 10'd3;
        repeat (20) step();
        check("starved_req", {15'd0, mem_req}, 16'd1);
        check("starved_addr", addr_out, 16'h2AC0);
        true_line     = 10'd0;
        true_column   = 10'd0;
        tile_pixel_in = 5'b10_011;
        step();
        check("starved_stale", {15'd0, palette_stale}, 16'd1);
        check("starved_req_drop", {15'd0, mem_req}, 16'd0);
        true_column = 10'd1;
        step();
        check("starved_old_colour", rgb_out, 16'h2726);
        n_req = 0;
        repeat (5) begin
            step();
            if (mem_req) n_req++;
        end
        check("starved_no_req", 16'(n_req), 16'd0);

        // Good load next frame with different VRAM contents.
        vofs = 8'h40;
        run_load(1'b0, 16'h2726);
        check("stale_held_preload", {15'd0, palette_stale}, 16'd1);
        true_line     = 10'd0;
        true_column   = 10'd0;
        tile_pixel_in = 5'b10_011;
        step();
        check("recover_stale_clr", {15'd0, palette_stale}, 16'd0);
        check("recover_commit_edge", rgb_out, 16'h2726);
        true_column = 10'd1;
        step();
        check("recover_entry19", rgb_out, 16'h6766);
        tile_pixel_in = 5'b01_000;
        step();
        check("recover_backdrop", rgb_out, 16'h4140);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
